mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 8: maximum consecutive grants to one owner while the other requester waits.
REQ-002 Parameter ADDR_W, default `ADDR_WIDTH (16): address width.
REQ-003 Parameter DATA_W, default `REG_WIDTH (8): data width.
REQ-004 clk  in  1  single clock for all state; rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 core_en  in  1  CPU running; low = host-only mode (program load while core is held).
REQ-007 host_req / core_req  in  1  access request, held until granted.
REQ-008 host_we / core_we  in  1  write when 1, read when 0.
REQ-009 host_addr / core_addr  in  ADDR_W  access address.
REQ-010 host_din / core_din  in  DATA_W  write data.
REQ-011 host_gnt / core_gnt  out  1  access accepted this cycle.
REQ-012 host_rvalid / core_rvalid  out  1  read data valid, one cycle after a granted read.
REQ-013 host_rdata / core_rdata  out  DATA_W  registered copy of mem_dout; 0 when rvalid is low.
REQ-014 core_stall  out  1  high when core_req is present but not granted.
REQ-015 mem_we  out  1; mem_addr  out  ADDR_W; mem_din  out  DATA_W  single memory port.
REQ-016 mem_dout  in  DATA_W  memory read data, valid one cycle after the address.

Function
REQ-017 FSM states: IDLE, HOST, CORE; the state names the current owner.
REQ-018 Grants are combinational from the state and the requests; the granted requester's we/addr/din drive the mem_* outputs in the same cycle.
REQ-019 When no grant is active, mem_we=0, mem_addr=0, mem_din=0.
REQ-020 At most one of host_gnt and core_gnt is high in any cycle.
REQ-021 IDLE: core_req&core_en -> grant core, next CORE; else host_req -> grant host, next HOST; else stay in IDLE. On a simultaneous request with core_en=1, the core wins.
REQ-022 CORE: core_req&core_en granted while burst_cnt<MAX_BURST or host_req=0; otherwise host granted if host_req, next HOST; with no request, next IDLE.
REQ-023 HOST: symmetric to CORE with roles swapped. The core is considered waiting only when core_en=1.
REQ-024 burst_cnt is a counter wide enough for MAX_BURST; it resets to 0 on an owner change or in IDLE, increments per grant to the same owner, and saturates at MAX_BURST.
REQ-025 core_en=0: core_gnt is never asserted; CORE state exits to HOST or IDLE in the next cycle; core_stall=core_req.
REQ-026 A granted read sets a 1-entry pending tag (owner) for the next cycle only. rvalid and rdata go to the tagged owner; a write never raises rvalid.
REQ-027 Back-to-back granted reads by different owners each get exactly one rvalid, in grant order.
REQ-028 Fairness: neither requester waits more than MAX_BURST+1 cycles while it holds req continuously (and core_en=1 for the core).

Reset
REQ-029 When reset=1 at a clock edge: state=IDLE, burst_cnt=0, pending tag cleared, all rvalid=0, all rdata=0.
REQ-030 During reset, all gnt outputs, mem_we and core_stall are forced to 0.
REQ-031 A reset asserted mid-burst, or with a read pending, drops that read; no rvalid follows.

Structure
REQ-032 The FSM state encoding (IDLE/HOST/CORE) and the MAX_BURST default belong in PKG/pkg.v beside ADDR_WIDTH/REG_WIDTH.
REQ-033 One sub-module: arb_burst_counter (saturating counter with clear and increment).

Verification
REQ-034 Host-only load, core_en=0: host writes 0xA5 to 0x0600 then reads 0x0600 -> host_gnt both cycles, host_rvalid one cycle later with host_rdata=0xA5, core_gnt=0 throughout.
REQ-035 Simultaneous host_req/core_req from IDLE, core_en=1 -> core_gnt first; after 8 core grants, host_gnt on the 9th cycle; core_stall=1 that cycle.
REQ-036 Interleaved reads: core reads 0x0600 (0x11), host reads 0x0601 (0x22) on consecutive cycles -> core_rvalid/0x11, then host_rvalid/0x22, no crossover.
REQ-037 Reset pulse the cycle after a granted read -> no rvalid, state IDLE, mem_we=0.
REQ-038 core_en dropped while in CORE with host_req=1 -> host_gnt the next cycle, core_gnt=0, core_stall=core_req.
REQ-039 Random requests for 10k cycles -> grants never overlap, wait never exceeds 9 cycles, read data matches a memory model.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared widths, burst limit and FSM state encoding for the two-port memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_WIDTH    = 16;
  localparam int unsigned REG_WIDTH     = 8;
  localparam int unsigned MAX_BURST_DEF = 8;

  // The state names the current owner; StIdle doubles as "no owner" for grant and read tags.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHost = 2'd1,
    StCore = 2'd2
  } arb_state_e;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/arb_burst_counter.sv
// Saturating burst counter: clear restarts the count, clear with increment loads one.
module arb_burst_counter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned Max   = MAX_BURST_DEF,
  parameter int unsigned Width = cnt_width(Max)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  localparam logic [Width-1:0] MaxVal = Width'(Max);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = inc_i ? Width'(1) : '0;
    end else if (inc_i && (cnt_q < MaxVal)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Host/core arbiter for a single synchronous memory port with bounded bursts and
// owner-tagged read return.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = MAX_BURST_DEF,
  parameter int unsigned ADDR_W    = ADDR_WIDTH,
  parameter int unsigned DATA_W    = REG_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_en,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_din,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_din,
  output logic              host_gnt,
  output logic              core_gnt,
  output logic              host_rvalid,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int unsigned CntW = cnt_width(MAX_BURST);

  arb_state_e      state_d, state_q;
  arb_state_e      pend_d, pend_q;
  arb_state_e      grant;
  logic [CntW-1:0] burst_cnt;
  logic            burst_full;
  logic            core_want;

  // A core request only counts while the CPU is running.
  assign core_want  = core_req & core_en;
  assign burst_full = (burst_cnt == CntW'(MAX_BURST));

  always_comb begin
    grant = StIdle;
    unique case (state_q)
      StIdle: begin
        if (core_want)     grant = StCore;
        else if (host_req) grant = StHost;
      end
      StCore: begin
        if (core_want && (!burst_full || !host_req)) grant = StCore;
        else if (host_req)                           grant = StHost;
      end
      StHost: begin
        if (host_req && (!burst_full || !core_want)) grant = StHost;
        else if (core_want)                          grant = StCore;
      end
      default: grant = StIdle;
    endcase
    if (reset) grant = StIdle;
    state_d = grant;
  end

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    unique case (grant)
      StHost: begin
        mem_we   = host_we;
        mem_addr = host_addr;
        mem_din  = host_din;
      end
      StCore: begin
        mem_we   = core_we;
        mem_addr = core_addr;
        mem_din  = core_din;
      end
      default: ;
    endcase
  end

  assign host_gnt   = (grant == StHost);
  assign core_gnt   = (grant == StCore);
  assign core_stall = core_req & ~core_gnt & ~reset;

  // Tag a granted read with its owner so the returning data is routed for one cycle only.
  assign pend_d = ((grant != StIdle) && !mem_we) ? grant : StIdle;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pend_q  <= StIdle;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  arb_burst_counter #(
    .Max   (MAX_BURST),
    .Width (CntW)
  ) u_burst_counter (
    .clk_i   (clk),
    .reset_i (reset),
    .clr_i   ((grant != state_q) || (grant == StIdle)),
    .inc_i   (grant != StIdle),
    .cnt_o   (burst_cnt)
  );

  // mem_dout is the memory's own registered output; a reset cycle suppresses a pending return.
  assign host_rvalid = (pend_q == StHost) & ~reset;
  assign core_rvalid = (pend_q == StCore) & ~reset;
  assign host_rdata  = host_rvalid ? mem_dout : '0;
  assign core_rdata  = core_rvalid ? mem_dout : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios followed by randomized requests.
module tb_mem_arbiter;

  localparam int unsigned MB = 8;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          reset, core_en;
  logic          host_req, host_we, core_req, core_we;
  logic [AW-1:0] host_addr, core_addr, mem_addr;
  logic [DW-1:0] host_din, core_din, mem_din, mem_dout;
  logic          host_gnt, core_gnt, host_rvalid, core_rvalid, core_stall, mem_we;
  logic [DW-1:0] host_rdata, core_rdata;

  mem_arbiter #(
    .MAX_BURST (MB),
    .ADDR_W    (AW),
    .DATA_W    (DW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .core_en     (core_en),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_din    (host_din),
    .core_req    (core_req),
    .core_we     (core_we),
    .core_addr   (core_addr),
    .core_din    (core_din),
    .host_gnt    (host_gnt),
    .core_gnt    (core_gnt),
    .host_rvalid (host_rvalid),
    .core_rvalid (core_rvalid),
    .host_rdata  (host_rdata),
    .core_rdata  (core_rdata),
    .core_stall  (core_stall),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_dout    (mem_dout)
  );

  always #5 clk = ~clk;

  // Synchronous RAM driven by the DUT's memory port.
  logic [DW-1:0] ram [0:65535];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  typedef struct {
    int          owner;  // 1 host, 2 core
    logic [7:0]  data;
    int          cyc;
  } rd_t;

  rd_t        rdq[$];
  logic [7:0] shadow [0:65535];
  int         n_cmp = 0, n_bad = 0, cyc = 0;
  int         own = 0, run = 0;  // reference owner (0 none) and consecutive grants
  int         hwait = 0, cwait = 0;
  bit         last_hg = 0, last_cg = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input bit rst, input bit en,
                      input bit hr, input bit hw, input logic [15:0] ha, input logic [7:0] hd,
                      input bit cr, input bit cw, input logic [15:0] ca, input logic [7:0] cd);
    int         g;
    bit         own_req, oth_req, ce;
    bit         ewe;
    logic [15:0] eaddr;
    logic [7:0]  edin;
    @(posedge clk);
    cyc++;
    #1;
    reset = rst; core_en = en;
    host_req = hr; host_we = hw; host_addr = ha; host_din = hd;
    core_req = cr; core_we = cw; core_addr = ca; core_din = cd;
    #1;
    ce = cr && en;
    g  = 0;
    if (!rst) begin
      if (own == 0) begin
        g = ce ? 2 : (hr ? 1 : 0);
      end else begin
        own_req = (own == 1) ? hr : ce;
        oth_req = (own == 1) ? ce : hr;
        if (own_req && (run < MB || !oth_req)) g = own;
        else if (oth_req)                      g = 3 - own;
      end
    end
    ewe = 0; eaddr = '0; edin = '0;
    if (g == 1) begin ewe = hw; eaddr = ha; edin = hd; end
    if (g == 2) begin ewe = cw; eaddr = ca; edin = cd; end
    check("host_gnt", host_gnt, g == 1);
    check("core_gnt", core_gnt, g == 2);
    check("mem_we", mem_we, ewe);
    check("mem_addr", mem_addr, eaddr);
    check("mem_din", mem_din, edin);
    check("core_stall", core_stall, cr && (g != 2) && !rst);
    check("gnt_overlap", host_gnt & core_gnt, 0);
    // Fairness: count cycles a held request goes ungranted.
    if (hr && !rst && !host_gnt) hwait++; else hwait = 0;
    if (ce && !rst && !core_gnt) cwait++; else cwait = 0;
    if (hwait > 0) check("host_wait_bound", (hwait > MB + 1), 0);
    if (cwait > 0) check("core_wait_bound", (cwait > MB + 1), 0);
    if (rst) rdq.delete();
    if (g != 0) begin
      if (ewe) shadow[eaddr] = edin;
      else     rdq.push_back('{owner: g, data: shadow[eaddr], cyc: cyc});
    end
    run     = (g == 0) ? 0 : ((g == own) ? ((run + 1 > MB) ? MB : run + 1) : 1);
    own     = g;
    last_hg = (g == 1);
    last_cg = (g == 2);
  endtask

  // Monitor: consumes expected reads whenever the DUT returns data.
  initial begin
    rd_t e;
    wait (cyc >= 2);
    forever begin
      @(negedge clk);
      while (rdq.size() > 0 && rdq[0].cyc < cyc - 1) begin
        n_cmp++; n_bad++;
        $display("FAIL rvalid_missing cyc=%0d: got none, expected owner %0d", cyc, rdq[0].owner);
        void'(rdq.pop_front());
      end
      if (host_rvalid || core_rvalid) begin
        if (rdq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rvalid_spurious cyc=%0d: got h=%0b c=%0b, expected none",
                   cyc, host_rvalid, core_rvalid);
        end else begin
          e = rdq.pop_front();
          check("rvalid_owner", {host_rvalid, core_rvalid}, (e.owner == 1) ? 2'b10 : 2'b01);
          check("rvalid_cycle", e.cyc, cyc - 1);
          check("rdata", (e.owner == 1) ? host_rdata : core_rdata, e.data);
        end
      end
      if (!host_rvalid) check("host_rdata_idle", host_rdata, 0);
      if (!core_rvalid) check("core_rdata_idle", core_rdata, 0);
    end
  end

  initial begin
    bit          h_r, h_w, c_r, c_w, en, rst, hreq35;
    logic [15:0] h_a, c_a;
    logic [7:0]  h_d, c_d;
    int          first_h;
    reset = 1; core_en = 0; host_req = 0; host_we = 0; host_addr = '0; host_din = '0;
    core_req = 0; core_we = 0; core_addr = '0; core_din = '0;
    for (int i = 0; i < 65536; i++) shadow[i] = '0;

    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Program load with the core held: prefill the working window.
    for (int i = 0; i < 16; i++) begin
      h_a = 16'h0600 + 16'(i);
      step(0, 0, 1, 1, h_a, 8'($urandom), 0, 0, 0, 0);
    end
    step(0, 0, 1, 1, 16'h0600, 8'hA5, 1, 0, 16'h0601, 0);
    check("load_write_gnt", host_gnt, 1);
    step(0, 0, 1, 0, 16'h0600, 0, 1, 0, 16'h0601, 0);
    check("load_read_gnt", host_gnt, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Simultaneous requests from idle: core bursts, host gets in on the 9th cycle.
    hreq35  = 1;
    first_h = 0;
    for (int i = 1; i <= 11; i++) begin
      c_a = 16'h0600 + 16'(i);
      step(0, 1, hreq35, 0, 16'h0601, 0, 1, 0, c_a, 0);
      if (last_hg && first_h == 0) begin
        first_h = i;
        check("burst_stall", core_stall, 1);
      end
      if (last_hg) hreq35 = 0;
    end
    check("host_first_grant", first_h, MB + 1);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Interleaved reads of two owners on consecutive cycles.
    step(0, 0, 1, 1, 16'h0600, 8'h11, 0, 0, 0, 0);
    step(0, 0, 1, 1, 16'h0601, 8'h22, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 1, 0, 16'h0600, 0);
    step(0, 1, 1, 0, 16'h0601, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset right after a granted read: the read is dropped.
    step(0, 1, 1, 0, 16'h0602, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("reset_mem_we", mem_we, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // core_en dropped while the core owns the port.
    step(0, 1, 1, 0, 16'h0603, 0, 1, 0, 16'h0604, 0);
    step(0, 0, 1, 0, 16'h0603, 0, 1, 0, 16'h0605, 0);
    check("en_drop_host_gnt", host_gnt, 1);
    step(0, 0, 0, 0, 0, 0, 1, 0, 16'h0605, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic; requests are held until the reference model grants them.
    h_r = 0; c_r = 0; en = 1;
    h_w = 0; c_w = 0; h_a = 0; c_a = 0; h_d = 0; c_d = 0;
    for (int i = 0; i < 10000; i++) begin
      if (!h_r || last_hg) begin
        h_r = ($urandom_range(0, 9) < 6);
        h_w = 1'($urandom_range(0, 1));
        h_a = 16'h0600 + 16'($urandom_range(0, 15));
        h_d = 8'($urandom);
      end
      if (!c_r || last_cg) begin
        c_r = ($urandom_range(0, 9) < 7);
        c_w = 1'($urandom_range(0, 1));
        c_a = 16'h0600 + 16'($urandom_range(0, 15));
        c_d = 8'($urandom);
      end
      if ($urandom_range(0, 49) == 0) en = ~en;
      rst = ($urandom_range(0, 199) == 0);
      step(rst, en, h_r, h_w, h_a, h_d, c_r, c_w, c_a, c_d);
    end

    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("reads_outstanding", rdq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
